pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer, used between stages of the RISC-V pipeline. It generalises the fixed-width stage register to arbitrary payload width and a configurable reset value, and adds backpressure (stall), flush, and occupancy reporting. It passes one transfer per cycle at full throughput while keeping every output, including `in_ready`, registered.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register.
//   pipe_state_e : occupancy state of a stage (EMPTY / BUSY / FULL), encoded so
//                  the state value equals the number of held entries.
//   PIPE_OCC_W   : width of the occupancy report.
// ----------------------------------------------------------------------------
package pipe_pkg;

   localparam int PIPE_OCC_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no entries held
      BUSY  = 2'd1,   // main register valid
      FULL  = 2'd2    // main and skid registers valid
   } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. Sustains one transfer per cycle while keeping in_ready registered:
// when the consumer stalls, the entry already in flight lands in the skid
// register instead of being dropped.
//
// Parameters
//   WIDTH      payload width in bits
//   RESET_VAL  value loaded into both data registers on reset
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry (registered)
//   out_ready  downstream consumes this cycle; low stalls the stage
//   out_data   head entry (registered)
//   flush      discard all held entries
//   occupancy  number of entries held, 0..2 (registered)
// ----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  flush,
   output logic [PIPE_OCC_W-1:0] occupancy
);

   pipe_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q,  main_d;
   logic [WIDTH-1:0] skid_q,  skid_d;
   logic             accept;
   logic             pop;

   // All outputs are pure decodes of flopped state; no input reaches an output.
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != FULL);
   assign occupancy = PIPE_OCC_W'(state_q);
   assign out_data  = main_q;

   assign accept = in_valid  & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         // Only validity clears; data registers keep their contents and an
         // input accepted in this cycle is thrown away.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = BUSY;
                  main_d  = in_data;
               end
            end
            BUSY: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (accept) begin
                  // Consumer stalled while a new entry arrived: park it.
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can change anything.
               if (pop) begin
                  state_d = BUSY;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int         W    = 8;
   localparam logic [7:0] RVAL = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       flush;
   logic [1:0] occupancy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   typedef struct {
      logic       rst_n;
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_ir;
      logic [1:0] e_occ;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic ov, input logic [7:0] od,
                          input logic ir, input logic [1:0] occ);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".out_data"},  32'(out_data),  32'(od));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
   endtask

   logic [7:0] q[$];
   logic       m_acc, m_pop, prev_stall;
   logic [7:0] stall_data;

   initial begin
      //           rst  iv  d      ordy fl    ov  od     ir  occ
      vecs[0]  = '{1'b0,1'b1,8'h11,1'b1,1'b0, 1'b0,8'hA5,1'b1,2'd0}; // reset, handshake ignored
      vecs[1]  = '{1'b0,1'b1,8'h11,1'b1,1'b0, 1'b0,8'hA5,1'b1,2'd0};
      vecs[2]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'hA5,1'b1,2'd0}; // idle after release
      vecs[3]  = '{1'b1,1'b1,8'h20,1'b0,1'b0, 1'b1,8'h20,1'b1,2'd1}; // stall: EMPTY->BUSY
      vecs[4]  = '{1'b1,1'b1,8'h21,1'b0,1'b0, 1'b1,8'h20,1'b0,2'd2}; // BUSY->FULL (skid)
      vecs[5]  = '{1'b1,1'b1,8'h22,1'b0,1'b0, 1'b1,8'h20,1'b0,2'd2}; // 0x22 refused
      vecs[6]  = '{1'b1,1'b1,8'h22,1'b1,1'b0, 1'b1,8'h21,1'b1,2'd1}; // pop: main<-skid
      vecs[7]  = '{1'b1,1'b1,8'h22,1'b1,1'b0, 1'b1,8'h22,1'b1,2'd1}; // 0x22 accepted
      vecs[8]  = '{1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h22,1'b1,2'd0}; // drain
      vecs[9]  = '{1'b1,1'b1,8'h30,1'b0,1'b0, 1'b1,8'h30,1'b1,2'd1};
      vecs[10] = '{1'b1,1'b1,8'h31,1'b0,1'b0, 1'b1,8'h30,1'b0,2'd2}; // FULL 30/31
      vecs[11] = '{1'b1,1'b1,8'h32,1'b0,1'b1, 1'b0,8'h30,1'b1,2'd0}; // flush while FULL
      vecs[12] = '{1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h30,1'b1,2'd0}; // 0x32 never shows
      vecs[13] = '{1'b1,1'b1,8'h40,1'b1,1'b0, 1'b1,8'h40,1'b1,2'd1};
      vecs[14] = '{1'b1,1'b1,8'h41,1'b1,1'b1, 1'b0,8'h40,1'b1,2'd0}; // flush drops accept
      vecs[15] = '{1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h40,1'b1,2'd0};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

      for (int i = 0; i < NV; i++) begin
         rst_n     = vecs[i].rst_n;
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         out_ready = vecs[i].ordy;
         flush     = vecs[i].fl;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_occ);
      end

      // Streaming 0x01..0x10 with out_ready high: 1-cycle latency, occupancy 1.
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
         chk_all($sformatf("stream%0d", i), 1'b1, 8'(i), 1'b1, 2'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_end.out_valid", 32'(out_valid), 32'd0);
      chk("stream_end.occupancy", 32'(occupancy), 32'd0);

      // Reset mid-stream while FULL.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h50; tick();
      in_data = 8'h51; tick();
      chk("midrst_full.occupancy", 32'(occupancy), 32'd2);
      rst_n = 1'b0; in_data = 8'h52; tick();
      chk_all("midrst", 1'b0, RVAL, 1'b1, 2'd0);
      rst_n = 1'b1; in_data = 8'h60; tick();
      chk_all("post_rst", 1'b1, 8'h60, 1'b1, 2'd1);
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("post_rst_drain.occupancy", 32'(occupancy), 32'd0);

      // Random traffic against a reference queue (stage is EMPTY here).
      prev_stall = 1'b0;
      stall_data = '0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
         chk("rnd.occupancy", 32'(occupancy), 32'(q.size()));
         if (q.size() > 0) chk("rnd.out_data", 32'(out_data), 32'(q[0]));
         if (prev_stall)   chk("rnd.stall_stable", 32'(out_data), 32'(stall_data));
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         m_acc = in_valid && (q.size() < 2);
         m_pop = out_ready && (q.size() > 0);
         prev_stall = (q.size() > 0) && !out_ready;
         if (q.size() > 0) stall_data = q[0];
         tick();
         if (m_pop) void'(q.pop_front());
         if (m_acc) q.push_back(in_data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pipe_stage_reg
